// File: rtl/boton_eventos.sv
// Classifies the debounced button level into one-cycle click, double-click
// and long-press events, timing every window with a 1 ms enable pulse.
module boton_eventos #(
  parameter int unsigned LONG_MS   = 3000,
  parameter int unsigned DOUBLE_MS = 300,
  parameter int unsigned CNT_W     = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_ms,
  input  logic btn_level,
  output logic evt_short,
  output logic evt_double,
  output logic evt_long,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_MS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ms_cnt;
  logic             sync1, sync2, prev;
  logic             rise, fall;
  logic             short_nxt, double_nxt, long_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn_level;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;

  // Edges are tested before timeouts so that a release or re-press wins a
  // tie with the expiring tick.
  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = PRESS;
      end
      PRESS: begin
        if (fall) begin
          state_nxt = WAIT2;
        end else if (tick_ms && ms_cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = LONG;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_nxt = PRESS2;
        end else if (tick_ms && ms_cnt == DOUBLE_LAST) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      PRESS2: begin
        if (fall) begin
          double_nxt = 1'b1;
          state_nxt  = IDLE;
        end else if (tick_ms && ms_cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = LONG;
        end
      end
      LONG: begin
        if (fall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ms_cnt     <= '0;
      evt_short  <= 1'b0;
      evt_double <= 1'b0;
      evt_long   <= 1'b0;
      held       <= 1'b0;
    end else begin
      state      <= state_nxt;
      evt_short  <= short_nxt;
      evt_double <= double_nxt;
      evt_long   <= long_nxt;
      held       <= (state_nxt == LONG);
      if (state_nxt != state) begin
        ms_cnt <= '0;
      end else if (tick_ms && ms_cnt != '1) begin
        ms_cnt <= ms_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_boton_eventos.sv
// Directed bench for boton_eventos: an event-level model checked every cycle,
// plus hand-computed event timings for each scenario.
module tb_boton_eventos;

  localparam int LONG_MS   = 20;
  localparam int DOUBLE_MS = 5;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic reset;
  logic tick_ms;
  logic btn_level;
  logic evt_short, evt_double, evt_long, held;

  boton_eventos #(
    .LONG_MS  (LONG_MS),
    .DOUBLE_MS(DOUBLE_MS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_ms   (tick_ms),
    .btn_level (btn_level),
    .evt_short (evt_short),
    .evt_double(evt_double),
    .evt_long  (evt_long),
    .held      (held)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // Model: the button as seen after the two-flop synchronizer, and what the
  // user is doing with it (holding, long-holding, between clicks).
  logic h1, h2, h3;
  logic m_pressed, m_long, m_pending, m_second;
  int   m_elapsed;
  logic e_s, e_d, e_l, e_h;

  int n_short = 0, n_double = 0, n_long = 0;
  int c_short = 0, c_double = 0, c_long = 0;

  task automatic chk(input string name, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    h1 = 0; h2 = 0; h3 = 0;
    m_pressed = 0; m_long = 0; m_pending = 0; m_second = 0;
    m_elapsed = 0;
    e_s = 0; e_d = 0; e_l = 0; e_h = 0;
  endtask

  task automatic model_edge();
    logic rise, fall, changed;
    rise = h2 & ~h3;
    fall = ~h2 & h3;
    changed = 0;
    e_s = 0; e_d = 0; e_l = 0;
    if (m_long) begin
      if (fall) begin m_long = 0; changed = 1; end
    end else if (m_pressed) begin
      if (fall) begin
        m_pressed = 0;
        if (m_second) begin e_d = 1; m_second = 0; end
        else m_pending = 1;
        changed = 1;
      end else if (tick_ms && m_elapsed == LONG_MS - 1) begin
        e_l = 1; m_long = 1; m_pressed = 0; m_second = 0; changed = 1;
      end
    end else if (m_pending) begin
      if (rise) begin
        m_pending = 0; m_pressed = 1; m_second = 1; changed = 1;
      end else if (tick_ms && m_elapsed == DOUBLE_MS - 1) begin
        e_s = 1; m_pending = 0; changed = 1;
      end
    end else if (rise) begin
      m_pressed = 1; m_second = 0; changed = 1;
    end
    if (changed) m_elapsed = 0;
    else if (tick_ms && m_elapsed < (1 << CNT_W) - 1) m_elapsed++;
    e_h = m_long;
    h3 = h2; h2 = h1; h1 = btn_level;
  endtask

  // One clock: model at the edge, compare 1 ns later, drive at +2 ns.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!reset) model_clear();
    else model_edge();
    #1;
    chk("outputs", int'({evt_short, evt_double, evt_long, held}),
        int'({e_s, e_d, e_l, e_h}));
    if (evt_short)  begin n_short++;  c_short  = cyc; end
    if (evt_double) begin n_double++; c_double = cyc; end
    if (evt_long)   begin n_long++;   c_long   = cyc; end
    #1;
    tick_ms = (cyc % 10 == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves the bench at +2 ns after an edge with cyc % 10 == 8, so a level
  // driven now reaches the FSM on an edge that also samples a tick.
  task automatic align();
    do step(); while (cyc % 10 != 8);
  endtask

  int s0, d0, l0, mark;

  initial begin
    reset = 0; btn_level = 0; tick_ms = 0;
    model_clear();
    run(3);
    chk("reset_outputs", int'({evt_short, evt_double, evt_long, held}), 0);
    reset = 1;
    run(20);

    // Single click: short fires 53 cycles after the release is driven.
    align(); s0 = n_short; d0 = n_double; l0 = n_long;
    btn_level = 1; run(80);
    btn_level = 0; mark = cyc; run(100);
    chk("single_short_count", n_short - s0, 1);
    chk("single_short_time", c_short - mark, 53);
    chk("single_other_events", (n_double - d0) + (n_long - l0), 0);

    // Double click.
    align(); s0 = n_short; d0 = n_double; l0 = n_long;
    btn_level = 1; run(30);
    btn_level = 0; run(20);
    btn_level = 1; run(30);
    btn_level = 0; mark = cyc; run(80);
    chk("double_count", n_double - d0, 1);
    chk("double_latency", c_double - mark, 3);
    chk("double_no_short", n_short - s0, 0);

    // Long hold of 30 ms.
    align(); s0 = n_short; l0 = n_long;
    btn_level = 1; mark = cyc; run(300);
    chk("long_time", c_long - mark, 203);
    chk("long_held_on", int'(held), 1);
    btn_level = 0; run(2);
    chk("long_held_before_fall", int'(held), 1);
    run(1);
    chk("long_held_after_fall", int'(held), 0);
    run(100);
    chk("long_count", n_long - l0, 1);
    chk("long_no_short", n_short - s0, 0);

    // Click then hold: long from PRESS2.
    align(); s0 = n_short; d0 = n_double; l0 = n_long;
    btn_level = 1; run(30);
    btn_level = 0; run(20);
    btn_level = 1; mark = cyc; run(250);
    chk("press2_long_time", c_long - mark, 203);
    chk("press2_held", int'(held), 1);
    btn_level = 0; run(60);
    chk("press2_long_count", n_long - l0, 1);
    chk("press2_no_click", (n_short - s0) + (n_double - d0), 0);

    // Re-press lands on the WAIT2 expiry tick: no short, second press wins.
    align(); s0 = n_short; d0 = n_double;
    btn_level = 1; run(30);
    btn_level = 0; run(50);
    btn_level = 1; run(40);
    btn_level = 0; mark = cyc; run(80);
    chk("race_wait2_no_short", n_short - s0, 0);
    chk("race_wait2_double", n_double - d0, 1);
    chk("race_wait2_double_latency", c_double - mark, 3);

    // Release lands on the long-expiry tick: release wins, click follows.
    align(); s0 = n_short; l0 = n_long;
    btn_level = 1; run(200);
    btn_level = 0; mark = cyc; run(80);
    chk("race_long_no_long", n_long - l0, 0);
    chk("race_long_short", n_short - s0, 1);
    chk("race_long_short_time", c_short - mark, 53);

    // Reset in the middle of a press with the button still down.
    align(); l0 = n_long;
    btn_level = 1; run(50);
    reset = 0; #1;
    chk("midreset_outputs", int'({evt_short, evt_double, evt_long, held}), 0);
    run(5);
    reset = 1; mark = cyc; run(250);
    chk("midreset_long_count", n_long - l0, 1);
    chk("midreset_long_time", c_long - mark, 198);
    btn_level = 0; run(20);
    chk("final_held", int'(held), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
